// File: rtl/branch_sequencer_pkg.sv
// Shared CPU definitions: opcodes, sequencer state encoding and C2 condition codes.
package branch_sequencer_pkg;

   localparam logic [4:0] OP_LD   = 5'b00000;
   localparam logic [4:0] OP_LDI  = 5'b00001;
   localparam logic [4:0] OP_ST   = 5'b00010;
   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_BR   = 5'b10010;
   localparam logic [4:0] OP_JR   = 5'b10011;
   localparam logic [4:0] OP_JAL  = 5'b10100;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_T3   = 3'd1,
      ST_T4   = 3'd2,
      ST_T5   = 3'd3,
      ST_T6   = 3'd4
   } state_e;

   localparam logic [3:0] C2_ZERO     = 4'b0000;
   localparam logic [3:0] C2_NONZERO  = 4'b0001;
   localparam logic [3:0] C2_POSITIVE = 4'b0010;
   localparam logic [3:0] C2_NEGATIVE = 4'b0011;

   function automatic logic [4:0] opcode_of(input logic [31:0] ir);
      return ir[31:27];
   endfunction

endpackage

// File: rtl/branch_sequencer_sat_counter.sv
// Saturating up-counter with enable; holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         en_i,
   output logic [W-1:0] count_o
);

   logic [W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (en_i && (count_q != {W{1'b1}}))
         count_d = count_q + {{(W-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) count_q <= '0;
      else         count_q <= count_d;
   end

   assign count_o = count_q;

endmodule

// File: rtl/branch_sequencer.sv
// T3..T6 execute-step sequencer for conditional branches, with taken/not-taken statistics.
module branch_sequencer
   import branch_sequencer_pkg::*;
#(
   parameter logic [4:0] BR_OPCODE = OP_BR,
   parameter int         CNT_W     = 16
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             start,
   input  logic [31:0]      IR,
   input  logic             Con,
   output logic             Gra,
   output logic             Rout,
   output logic             CONin,
   output logic             PCout,
   output logic             Yin,
   output logic             Cout,
   output logic             ADD,
   output logic             Zin,
   output logic             Zlowout,
   output logic             PCin,
   output logic             busy,
   output logic             done,
   output logic             illegal,
   output logic [CNT_W-1:0] taken_count,
   output logic [CNT_W-1:0] not_taken_count,
   output logic [2:0]       dbg_state_o
);

   state_e state_q, state_d;
   logic   illegal_q;
   logic   is_branch;
   logic   unused_ir;

   assign is_branch = (opcode_of(IR) == BR_OPCODE);
   assign unused_ir = ^IR[26:0];

   // IR is only looked at while idle; once in T3 the sequence runs to T6 regardless.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (start && is_branch) state_d = ST_T3;
         ST_T3:   state_d = ST_T4;
         ST_T4:   state_d = ST_T5;
         ST_T5:   state_d = ST_T6;
         ST_T6:   state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         state_q   <= ST_IDLE;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= (state_q == ST_IDLE) && start && !is_branch;
      end
   end

   assign Gra     = (state_q == ST_T3);
   assign Rout    = (state_q == ST_T3);
   assign CONin   = (state_q == ST_T3);
   assign PCout   = (state_q == ST_T4);
   assign Yin     = (state_q == ST_T4);
   assign Cout    = (state_q == ST_T5);
   assign ADD     = (state_q == ST_T5);
   assign Zin     = (state_q == ST_T5);
   assign Zlowout = (state_q == ST_T6);
   assign done    = (state_q == ST_T6);
   // Con has settled since T4, so it gates the PC write directly in T6.
   assign PCin    = (state_q == ST_T6) && Con;
   assign busy    = (state_q != ST_IDLE);
   assign illegal = illegal_q;
   assign dbg_state_o = state_q;

   sat_counter #(.W(CNT_W)) u_taken (
      .clk_i   (clock),
      .rst_ni  (clear),
      .en_i    ((state_q == ST_T6) && Con),
      .count_o (taken_count)
   );

   sat_counter #(.W(CNT_W)) u_not_taken (
      .clk_i   (clock),
      .rst_ni  (clear),
      .en_i    ((state_q == ST_T6) && !Con),
      .count_o (not_taken_count)
   );

endmodule

// File: tb/tb_branch_sequencer.sv
// Bench for branch_sequencer: table of branch/non-branch instructions plus multi-cycle corner cases.
module tb_branch_sequencer;
   import branch_sequencer_pkg::*;

   logic        clock = 1'b0;
   logic        clear, start, Con;
   logic [31:0] IR;

   logic        Gra, Rout, CONin, PCout, Yin, Cout, ADD, Zin, Zlowout, PCin, busy, done, illegal;
   logic [15:0] taken_count, not_taken_count;
   logic [2:0]  dbg_state;

   logic        s_Gra, s_Rout, s_CONin, s_PCout, s_Yin, s_Cout, s_ADD, s_Zin, s_Zlowout;
   logic        s_PCin, s_busy, s_done, s_illegal;
   logic [1:0]  s_taken, s_not_taken;
   logic [2:0]  s_dbg_state;

   always #5 clock = ~clock;

   branch_sequencer u_dut (
      .clock(clock), .clear(clear), .start(start), .IR(IR), .Con(Con),
      .Gra(Gra), .Rout(Rout), .CONin(CONin), .PCout(PCout), .Yin(Yin), .Cout(Cout),
      .ADD(ADD), .Zin(Zin), .Zlowout(Zlowout), .PCin(PCin), .busy(busy), .done(done),
      .illegal(illegal), .taken_count(taken_count), .not_taken_count(not_taken_count),
      .dbg_state_o(dbg_state)
   );

   branch_sequencer #(.CNT_W(2)) u_sat (
      .clock(clock), .clear(clear), .start(start), .IR(IR), .Con(Con),
      .Gra(s_Gra), .Rout(s_Rout), .CONin(s_CONin), .PCout(s_PCout), .Yin(s_Yin), .Cout(s_Cout),
      .ADD(s_ADD), .Zin(s_Zin), .Zlowout(s_Zlowout), .PCin(s_PCin), .busy(s_busy), .done(s_done),
      .illegal(s_illegal), .taken_count(s_taken), .not_taken_count(s_not_taken),
      .dbg_state_o(s_dbg_state)
   );

   // {Gra,Rout,CONin,PCout,Yin,Cout,ADD,Zin,Zlowout,PCin,busy,done,illegal}
   localparam logic [12:0] V_IDLE = 13'b0000000000000;
   localparam logic [12:0] V_T3   = 13'b1110000000100;
   localparam logic [12:0] V_T4   = 13'b0001100000100;
   localparam logic [12:0] V_T5   = 13'b0000011100100;
   localparam logic [12:0] V_T6   = 13'b0000000010110;
   localparam logic [12:0] V_PCIN = 13'b0000000001000;
   localparam logic [12:0] V_ILL  = 13'b0000000000001;

   logic [12:0] vec;
   assign vec = {Gra, Rout, CONin, PCout, Yin, Cout, ADD, Zin, Zlowout, PCin, busy, done, illegal};

   typedef struct {
      logic [31:0] ir;
      logic        con;
      logic        exp_legal;
      logic        exp_pcin;
   } vec_t;

   vec_t        tbl[8];
   logic [12:0] exp_q[$];
   int          checks = 0;
   int          failures = 0;
   int          exp_taken = 0;
   int          exp_nt = 0;

   function automatic int sat3(input int n);
      return (n > 3) ? 3 : n;
   endfunction

   task automatic check_vec(input string nm);
      logic [12:0] e;
      checks++;
      if (exp_q.size() == 0) begin
         failures++;
         $display("FAIL %s: no expected entry, got %b", nm, vec);
      end else begin
         e = exp_q.pop_front();
         if (vec !== e) begin
            failures++;
            $display("FAIL %s: got %b expected %b", nm, vec, e);
         end
      end
   endtask

   task automatic check_val(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   task automatic check_counters(input string nm);
      check_val({nm, " taken"}, int'(taken_count), exp_taken);
      check_val({nm, " not_taken"}, int'(not_taken_count), exp_nt);
      check_val({nm, " sat taken"}, int'(s_taken), sat3(exp_taken));
      check_val({nm, " sat not_taken"}, int'(s_not_taken), sat3(exp_nt));
   endtask

   // One start pulse, then six observed cycles; Con is the opposite value before T4.
   task automatic run_seq(input string nm, input logic [31:0] ir, input logic con,
                          input logic legal, input logic pcin);
      exp_q.push_back(V_IDLE);
      if (legal) begin
         exp_q.push_back(V_T3);
         exp_q.push_back(V_T4);
         exp_q.push_back(V_T5);
         exp_q.push_back(V_T6 | (pcin ? V_PCIN : V_IDLE));
         exp_q.push_back(V_IDLE);
         if (con) exp_taken++;
         else     exp_nt++;
      end else begin
         exp_q.push_back(V_ILL);
         for (int j = 0; j < 4; j++) exp_q.push_back(V_IDLE);
      end
      for (int k = 0; k < 6; k++) begin
         case (k)
            0: begin start = 1'b1; IR = ir; Con = ~con; end
            1: begin start = 1'b0; IR = $urandom; end
            2: Con = con;
            default: ;
         endcase
         @(negedge clock);
         check_vec($sformatf("%s k%0d", nm, k));
         @(posedge clock); #1;
      end
      check_counters(nm);
   endtask

   initial begin
      logic [31:0] rir;
      logic        rlegal, rcon;

      tbl[0] = '{32'h9080_0023, 1'b1, 1'b1, 1'b1};
      tbl[1] = '{32'h9080_0023, 1'b0, 1'b1, 1'b0};
      tbl[2] = '{32'h1880_0000, 1'b1, 1'b0, 1'b0};
      tbl[3] = '{32'h9780_0000, 1'b1, 1'b1, 1'b1};
      tbl[4] = '{32'h9000_0000, 1'b0, 1'b1, 1'b0};
      tbl[5] = '{32'hF800_0000, 1'b0, 1'b0, 1'b0};
      tbl[6] = '{32'h9F7F_FFFF, 1'b1, 1'b0, 1'b0};
      tbl[7] = '{32'h8800_0000, 1'b1, 1'b0, 1'b0};

      clear = 1'b0; start = 1'b0; IR = '0; Con = 1'b0;
      repeat (2) @(negedge clock);
      exp_q.push_back(V_IDLE);
      check_vec("reset outputs");
      check_counters("reset");
      @(posedge clock); #1;
      clear = 1'b1;

      for (int i = 0; i < 8; i++)
         run_seq($sformatf("tbl%0d", i), tbl[i].ir, tbl[i].con, tbl[i].exp_legal, tbl[i].exp_pcin);

      for (int i = 0; i < 8; i++) begin
         rlegal = 1'($urandom_range(0, 1));
         rcon   = 1'($urandom_range(0, 1));
         rir    = $urandom;
         if (rlegal) rir[31:27] = 5'b10010;
         else if (rir[31:27] == 5'b10010) rir[27] = 1'b1;
         run_seq($sformatf("rnd%0d", i), rir, rcon, rlegal, rlegal & rcon);
      end

      // start held for six cycles: second sequence begins in the idle cycle after T6
      exp_q.push_back(V_IDLE);
      for (int r = 0; r < 2; r++) begin
         exp_q.push_back(V_T3);
         exp_q.push_back(V_T4);
         exp_q.push_back(V_T5);
         exp_q.push_back(V_T6 | V_PCIN);
         exp_q.push_back(V_IDLE);
      end
      exp_taken += 2;
      Con = 1'b1;
      IR  = 32'h9080_0023;
      for (int k = 0; k < 11; k++) begin
         start = (k < 6);
         @(negedge clock);
         check_vec($sformatf("held_start k%0d", k));
         @(posedge clock); #1;
      end
      check_counters("held_start");

      // reset asserted during T5
      exp_q.push_back(V_IDLE);
      exp_q.push_back(V_T3);
      exp_q.push_back(V_T4);
      for (int k = 0; k < 3; k++) begin
         case (k)
            0: begin start = 1'b1; IR = 32'h9080_0023; Con = 1'b0; end
            1: start = 1'b0;
            2: Con = 1'b1;
            default: ;
         endcase
         @(negedge clock);
         check_vec($sformatf("mid_reset k%0d", k));
         @(posedge clock); #1;
      end
      exp_q.push_back(V_T5);
      check_vec("mid_reset in T5");
      clear = 1'b0;
      #1;
      exp_q.push_back(V_IDLE);
      check_vec("mid_reset immediate");
      exp_taken = 0;
      exp_nt = 0;
      check_counters("mid_reset");
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         exp_q.push_back(V_IDLE);
         check_vec($sformatf("mid_reset held k%0d", k));
      end
      @(posedge clock); #1;
      clear = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         exp_q.push_back(V_IDLE);
         check_vec($sformatf("post_reset idle k%0d", k));
      end
      @(posedge clock); #1;
      check_counters("post_reset");

      // five taken branches: the 2-bit counters stop at 3
      for (int i = 0; i < 5; i++)
         run_seq($sformatf("sat%0d", i), 32'h9080_0023, 1'b1, 1'b1, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
